// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter stage that sits directly behind the control unit. It
//   registers the PC, applies the next-PC select, and latches halt. It also
//   owns the round-robin quantum timer that produces the interrupt request
//   fed back to the control unit, tracks BIOS/IM mode, and records the PC
//   pre-empted by the last interrupt.
//
// Build option:
//   IRQ_MASK_BIOS_EN - when defined, the quantum timer does not count while
//                      bios_mode=1, so an interrupt can never be raised from
//                      BIOS. An interrupt already pending is still delivered.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   step_en      in   instruction-retire strobe; state moves only on steps
//   mux_pc       in   next-PC select (0 +1, 1 branch, 2 jump, 3 R[rs], 4 R[so])
//   imd          in   instruction immediate, sign-extended for branches
//   address      in   jump target field
//   data_rs      in   R[rs]
//   pc_so        in   OS entry PC, R[so]
//   halt         in   control-unit halt
//   finish       in   control-unit finish (disarms the timer)
//   flag_timer   in   setTimer strobe (loads quantum from timer_data)
//   flag_biosim  in   BIOS/IM toggle strobe
//   timer_data   in   quantum value
//   pc           out  current PC
//   pc_plus1     out  pc+1 (combinational)
//   interrupt    out  registered pre-emption request
//   saved_pc     out  PC pre-empted by the last interrupt
//   bios_mode    out  1 while executing from BIOS
//   halted       out  processor stopped (cleared only by reset)
//
// State table (run control FSM):
//   state      | meaning
//   ST_RUN     | steps retire normally
//   ST_HALTED  | halt seen; everything frozen until reset

module pc_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int TIMER_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               step_en,
    input  logic [2:0]         mux_pc,
    input  logic [15:0]        imd,
    input  logic [25:0]        address,
    input  logic [31:0]        data_rs,
    input  logic [31:0]        pc_so,
    input  logic               halt,
    input  logic               finish,
    input  logic               flag_timer,
    input  logic               flag_biosim,
    input  logic [TIMER_W-1:0] timer_data,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus1,
    output logic               interrupt,
    output logic [ADDR_W-1:0]  saved_pc,
    output logic               bios_mode,
    output logic               halted
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } run_state_t;

    run_state_t state, state_next;
    logic       adv;

    // Timer is held as a down-counter of steps remaining before expiry:
    // remain == quantum-1-count, so expiry is the terminal count remain==0.
    logic [TIMER_W-1:0] quantum, quantum_nxt;
    logic [TIMER_W-1:0] remain, remain_nxt;
    logic               armed, armed_nxt;
    logic               irq_nxt;
    logic [ADDR_W-1:0]  saved_nxt;
    logic               bios_nxt;
    logic [ADDR_W-1:0]  pc_next;
    logic [31:0]        imd_sext;
    logic               count_en;
    logic               unused_bits;

    assign imd_sext = {{16{imd[15]}}, imd};
    assign pc_plus1 = pc + ADDR_W'(1);
    assign halted   = (state == ST_HALTED);

    // Upper operand bits are outside the PC address space by design.
    assign unused_bits = ^{address[25:ADDR_W], data_rs[31:ADDR_W],
                           pc_so[31:ADDR_W], imd_sext[31:ADDR_W]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        adv        = 1'b0;
        case (state)
            ST_RUN: begin
                if (step_en) begin
                    if (halt) begin
                        state_next = ST_HALTED;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_comb begin
        pc_next = pc_plus1;
        case (mux_pc)
            3'd0:    pc_next = pc_plus1;
            3'd1:    pc_next = pc_plus1 + imd_sext[ADDR_W-1:0];
            3'd2:    pc_next = address[ADDR_W-1:0];
            3'd3:    pc_next = data_rs[ADDR_W-1:0];
            3'd4:    pc_next = pc_so[ADDR_W-1:0];
            default: pc_next = pc_plus1;
        endcase
    end

    always_comb begin
        quantum_nxt = quantum;
        remain_nxt  = remain;
        armed_nxt   = armed;
        irq_nxt     = interrupt;
        saved_nxt   = saved_pc;
        bios_nxt    = bios_mode;

`ifdef IRQ_MASK_BIOS_EN
        count_en = armed & ~interrupt & ~flag_timer & ~finish & ~flag_biosim
                   & ~bios_mode;
`else
        count_en = armed & ~interrupt & ~flag_timer & ~finish & ~flag_biosim;
`endif

        // The step that retires the interrupt records the pre-empted PC
        // and restarts the quantum; armed is left untouched.
        if (interrupt) begin
            saved_nxt  = pc;
            irq_nxt    = 1'b0;
            remain_nxt = quantum - TIMER_W'(1);
        end else if (count_en) begin
            if (remain == '0) begin
                irq_nxt    = 1'b1;
                remain_nxt = quantum - TIMER_W'(1);
            end else begin
                remain_nxt = remain - TIMER_W'(1);
            end
        end

        // Later assignments win: load over expiry, biosim/finish over load.
        if (flag_timer) begin
            quantum_nxt = timer_data;
            remain_nxt  = timer_data - TIMER_W'(1);
            armed_nxt   = (timer_data != '0);
        end

        if (flag_biosim) begin
            bios_nxt   = ~bios_mode;
            armed_nxt  = 1'b0;
            remain_nxt = quantum_nxt - TIMER_W'(1);
        end

        if (finish) begin
            armed_nxt  = 1'b0;
            remain_nxt = quantum_nxt - TIMER_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            interrupt <= 1'b0;
            saved_pc  <= '0;
            bios_mode <= 1'b1;
            quantum   <= '0;
            remain    <= '1;
            armed     <= 1'b0;
        end else if (adv) begin
            pc        <= pc_next;
            interrupt <= irq_nxt;
            saved_pc  <= saved_nxt;
            bios_mode <= bios_nxt;
            quantum   <= quantum_nxt;
            remain    <= remain_nxt;
            armed     <= armed_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps followed by random
// steps, all compared against a count-up behavioural model of the stage.
module tb_pc_sequencer;

    localparam int ADDR_W  = 10;
    localparam int TIMER_W = 16;
    localparam int MASK    = (1 << ADDR_W) - 1;

    logic               clock;
    logic               reset;
    logic               s_step;
    logic [2:0]         s_mux;
    logic [15:0]        s_imd;
    logic [25:0]        s_addr;
    logic [31:0]        s_rs;
    logic [31:0]        s_so;
    logic               s_halt;
    logic               s_fin;
    logic               s_ft;
    logic               s_fb;
    logic [TIMER_W-1:0] s_td;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus1;
    logic               interrupt;
    logic [ADDR_W-1:0]  saved_pc;
    logic               bios_mode;
    logic               halted;

    int errors = 0;
    int checks = 0;

    // model state
    int m_pc, m_int, m_saved, m_bios, m_halted;
    int m_quantum, m_count, m_armed;

    pc_sequencer #(.ADDR_W(ADDR_W), .TIMER_W(TIMER_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .step_en     (s_step),
        .mux_pc      (s_mux),
        .imd         (s_imd),
        .address     (s_addr),
        .data_rs     (s_rs),
        .pc_so       (s_so),
        .halt        (s_halt),
        .finish      (s_fin),
        .flag_timer  (s_ft),
        .flag_biosim (s_fb),
        .timer_data  (s_td),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .interrupt   (interrupt),
        .saved_pc    (saved_pc),
        .bios_mode   (bios_mode),
        .halted      (halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 0; m_int = 0; m_saved = 0; m_bios = 1; m_halted = 0;
        m_quantum = 0; m_count = 0; m_armed = 0;
    endtask

    // One retired step of the stage, applied from the current stimulus.
    task automatic m_step();
        int npc;
        bit cnt_ok;
        if (!s_step || m_halted != 0) return;
        if (s_halt) begin
            m_halted = 1;
            return;
        end
        case (s_mux)
            3'd1:    npc = m_pc + 1 + int'($signed(s_imd));
            3'd2:    npc = int'(s_addr[9:0]);
            3'd3:    npc = int'(s_rs[9:0]);
            3'd4:    npc = int'(s_so[9:0]);
            default: npc = m_pc + 1;
        endcase
        npc = npc & MASK;
        cnt_ok = (m_armed != 0) && (m_int == 0) && !s_ft && !s_fin && !s_fb;
`ifdef IRQ_MASK_BIOS_EN
        cnt_ok = cnt_ok && (m_bios == 0);
`endif
        if (m_int != 0) begin
            m_saved = m_pc;
            m_int   = 0;
            m_count = 0;
        end else if (cnt_ok) begin
            if (m_count == m_quantum - 1) begin
                m_count = 0;
                m_int   = 1;
            end else begin
                m_count = m_count + 1;
            end
        end
        if (s_ft) begin
            m_quantum = int'(s_td);
            m_count   = 0;
            m_armed   = (s_td != 0) ? 1 : 0;
        end
        if (s_fb) begin
            m_bios  = 1 - m_bios;
            m_armed = 0;
            m_count = 0;
        end
        if (s_fin) begin
            m_armed = 0;
            m_count = 0;
        end
        m_pc = npc;
    endtask

    task automatic check_all();
        chk("pc",        32'(pc),        32'(m_pc));
        chk("pc_plus1",  32'(pc_plus1),  32'((m_pc + 1) & MASK));
        chk("interrupt", 32'(interrupt), 32'(m_int));
        chk("saved_pc",  32'(saved_pc),  32'(m_saved));
        chk("bios_mode", 32'(bios_mode), 32'(m_bios));
        chk("halted",    32'(halted),    32'(m_halted));
    endtask

    task automatic idle();
        s_step = 1'b1; s_mux = 3'd0; s_imd = '0; s_addr = '0; s_rs = '0;
        s_so = '0; s_halt = 1'b0; s_fin = 1'b0; s_ft = 1'b0; s_fb = 1'b0;
        s_td = '0;
    endtask

    // Called just after an edge; drives nothing new, one clock of stepping.
    task automatic do_step();
        m_step();
        @(posedge clock);
        #1;
        check_all();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        #1;
        check_all();
        @(negedge clock);
        reset = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        s_step = 1'b0;
        reset  = 1'b1;
        m_reset();
        @(posedge clock);
        #1;
        do_reset();
        chk("reset_pc_const", 32'(pc), 32'd0);
        chk("reset_bios_const", 32'(bios_mode), 32'd1);

        // Sequential increments and wrap.
        for (int i = 1; i <= 3; i++) begin
            do_step();
            chk("pc_inc_const", 32'(pc), 32'(i));
        end
        s_mux = 3'd3; s_rs = 32'd1023; do_step();
        do_step();
        chk("pc_wrap_const", 32'(pc), 32'd0);

        // Branch, jump and register targets.
        s_mux = 3'd3; s_rs = 32'd5; do_step();
        s_mux = 3'd1; s_imd = 16'hFFFE; do_step();
        chk("pc_branch_const", 32'(pc), 32'd4);
        s_mux = 3'd2; s_addr = 26'h3FF_F123; do_step();
        chk("pc_jump_const", 32'(pc), 32'h123);
        s_mux = 3'd3; s_rs = 32'hFFFF_F2A7; do_step();
        chk("pc_rs_const", 32'(pc), 32'h2A7);
        s_mux = 3'd5; do_step();
        s_mux = 3'd7; do_step();

        // Leave BIOS so timer tests behave alike in every build.
        s_fb = 1'b1; do_step();
        chk("bios_off_const", 32'(bios_mode), 32'd0);

        // Quantum 3 from pc=10.
        s_ft = 1'b1; s_td = 16'd3; s_mux = 3'd3; s_rs = 32'd10; do_step();
        do_step();
        do_step();
        chk("irq_early_const", 32'(interrupt), 32'd0);
        do_step();
        chk("irq_q3_const", 32'(interrupt), 32'd1);
        chk("irq_q3_pc_const", 32'(pc), 32'd13);
        s_mux = 3'd4; s_so = 32'd100; do_step();
        chk("irq_take_pc_const", 32'(pc), 32'd100);
        chk("irq_saved_const", 32'(saved_pc), 32'd13);
        chk("irq_clear_const", 32'(interrupt), 32'd0);
        do_step();
        do_step();
        chk("irq_again_early_const", 32'(interrupt), 32'd0);
        do_step();
        chk("irq_again_const", 32'(interrupt), 32'd1);
        s_mux = 3'd4; s_so = 32'd200; do_step();

        // Step with step_en low changes nothing.
        s_step = 1'b0; s_mux = 3'd3; s_rs = 32'd77; do_step();

        // Quantum 2 then halt.
        s_ft = 1'b1; s_td = 16'd2; do_step();
        s_halt = 1'b1; do_step();
        chk("halted_const", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            s_mux = 3'(i % 5); s_rs = 32'(i); do_step();
        end
        chk("halt_noirq_const", 32'(interrupt), 32'd0);
        do_reset();
        chk("halt_cleared_const", 32'(halted), 32'd0);
        s_fb = 1'b1; do_step();

        // Quantum 0 never fires.
        s_ft = 1'b1; s_td = 16'd0; do_step();
        for (int i = 0; i < 20; i++) do_step();
        chk("q0_noirq_const", 32'(interrupt), 32'd0);

        // Quantum 5, finish at count 2.
        s_ft = 1'b1; s_td = 16'd5; do_step();
        do_step();
        do_step();
        s_fin = 1'b1; do_step();
        for (int i = 0; i < 10; i++) do_step();
        chk("finish_noirq_const", 32'(interrupt), 32'd0);

        // Finish and load together: finish wins.
        s_ft = 1'b1; s_td = 16'd1; s_fin = 1'b1; do_step();
        for (int i = 0; i < 4; i++) do_step();
        chk("finish_over_load_const", 32'(interrupt), 32'd0);

        // Reload on the expiry step suppresses the interrupt.
        s_ft = 1'b1; s_td = 16'd2; do_step();
        do_step();
        s_ft = 1'b1; s_td = 16'd2; do_step();
        chk("reload_wins_const", 32'(interrupt), 32'd0);
        do_step();
        do_step();
        chk("reload_then_fire_const", 32'(interrupt), 32'd1);
        s_mux = 3'd4; s_so = 32'd300; do_step();

        // Quantum 1 fires after every non-interrupt step.
        s_ft = 1'b1; s_td = 16'd1; do_step();
        for (int i = 0; i < 3; i++) begin
            do_step();
            chk("q1_fire_const", 32'(interrupt), 32'd1);
            s_mux = 3'd4; s_so = 32'd400; do_step();
            chk("q1_take_const", 32'(interrupt), 32'd0);
        end

        // Asynchronous reset mid-count with step_en low.
        s_ft = 1'b1; s_td = 16'd4; do_step();
        do_step();
        do_step();
        s_step = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_pc_const", 32'(pc), 32'd0);
        chk("async_saved_const", 32'(saved_pc), 32'd0);
        chk("async_bios_const", 32'(bios_mode), 32'd1);
        chk("async_irq_const", 32'(interrupt), 32'd0);
        do_reset();

        // Timer in BIOS mode (build option decides; model follows).
        s_ft = 1'b1; s_td = 16'd2; do_step();
        for (int i = 0; i < 6; i++) begin
            if (m_int != 0) s_mux = 3'd4;
            do_step();
        end

        // Randomised steps against the model.
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 99) begin
                do_reset();
            end else begin
                s_step = ($urandom_range(3) != 0);
                s_mux  = 3'($urandom_range(7));
                s_imd  = 16'($urandom);
                s_addr = 26'($urandom);
                s_rs   = $urandom;
                s_so   = $urandom;
                s_halt = ($urandom_range(79) == 0);
                s_fin  = ($urandom_range(15) == 0);
                s_ft   = ($urandom_range(9) == 0);
                s_fb   = ($urandom_range(19) == 0);
                s_td   = 16'($urandom_range(6));
                if (m_int != 0) s_mux = 3'd4;
                do_step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the control unit.
- Registers the PC and applies the control unit's next-PC select (MUX_PC code), halt and finish outputs.
- Contains the round-robin quantum timer. The timer is loaded by setTimer and produces the `interrupt` input that feeds back into the control unit.
- Also tracks BIOS/IM mode and records the PC that was pre-empted when an interrupt is taken.

Parameters:
- ADDR_W, 10, instruction-memory address width; PC width.
- TIMER_W, 16, quantum register and counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- step_en  in  1  instruction-retire strobe; state advances only on clock edges with step_en=1.
- mux_pc  in  3  next-PC select from the control unit.
- imd  in  16  instruction immediate [15:0], sign-extended internally.
- address  in  26  jump target, instruction [25:0].
- data_rs  in  32  R[rs] from the register file.
- pc_so  in  32  OS entry PC, R[so].
- halt  in  1  control-unit halt.
- finish  in  1  control-unit finish (jimset with rt=0).
- flag_timer  in  1  setTimer strobe.
- flag_biosim  in  1  BIOS/IM toggle strobe.
- timer_data  in  TIMER_W  quantum value (R[rs] low bits).
- pc  out  ADDR_W  current PC.
- pc_plus1  out  ADDR_W  pc+1, modulo 2^ADDR_W; combinational.
- interrupt  out  1  registered pre-emption request to the control unit.
- saved_pc  out  ADDR_W  PC of the instruction pre-empted by the last interrupt.
- bios_mode  out  1  1 = executing from BIOS.
- halted  out  1  processor stopped.

Behaviour:

Reset (asynchronous, effective immediately):
- pc=0, interrupt=0, saved_pc=0, bios_mode=1, halted=0.
- Quantum=0, count=0, armed=0.

Stepping:
- Nothing changes on an edge with step_en=0 or halted=1; interrupt holds its value.
- halt=1 with step_en=1: halted<=1; pc holds; timer state freezes. Halted is cleared only by reset.

Next PC on a step, all arithmetic modulo 2^ADDR_W:
- mux_pc 0: pc+1.
- mux_pc 1: pc+1+sext(imd).
- mux_pc 2: address[ADDR_W-1:0].
- mux_pc 3: data_rs[ADDR_W-1:0].
- mux_pc 4: pc_so[ADDR_W-1:0].
- mux_pc 5-7: pc+1.

Mode:
- flag_biosim step: bios_mode<=~bios_mode; armed<=0; count<=0.

Timer load:
- flag_timer step: quantum<=timer_data; count<=0; armed<=(timer_data!=0).
- A load takes priority over expiry and counting in the same step.
- finish step: armed<=0; count<=0. Finish takes priority over a load in the same step.

Counting:
- Each step with armed=1, interrupt=0 and no load/finish/biosim/halt: if count==quantum-1, then count<=0 and interrupt<=1; otherwise count<=count+1.

Interrupt step:
- The first step with interrupt=1 (the control unit forces mux_pc=4): saved_pc<=pc (the pre-empted, unexecuted instruction); interrupt<=0; count<=0; armed stays set.
- An interrupt is therefore high for exactly one retired step.

Corner cases:
- Wrap: pc=2^ADDR_W-1 with mux_pc=0 gives 0.
- Quantum=1: interrupt on the step after every non-interrupt step.

Optional Feature:
- Macro: IRQ_MASK_BIOS_EN.
- Defined: counting is suppressed while bios_mode=1, so interrupt never rises in BIOS. An interrupt already pending when entering BIOS is still delivered.
- Undefined: counting is independent of bios_mode.

Test Plan:
- Reset, then 3 steps with mux_pc=0: pc=1,2,3. With ADDR_W=10, pc=1023 and mux_pc=0: pc=0.
- pc=5, mux_pc=1, imd=0xFFFE: pc=4. mux_pc=2, address=0x123: pc=0x123. mux_pc=3, data_rs=0x2A7: pc=0x2A7.
- flag_timer with timer_data=3, then mux_pc=0 steps from pc=10:
  - interrupt=1 after the 3rd counted step, at pc=13.
  - Next step with mux_pc=4, pc_so=100: pc=100, saved_pc=13, interrupt=0.
  - Interrupt rises again 3 steps later.
- Arm quantum=2, then assert halt: halted=1; pc frozen; no interrupt over 10 further steps; reset clears everything.
- flag_timer with timer_data=0: no interrupt over 20 steps. Arm 5, then finish at count 2: no interrupt. flag_timer together with expiry: the reload wins and interrupt stays 0.
- Assert reset mid-count (count=2, quantum=4) with step_en low: all outputs return to reset values with no clock edge; bios_mode=1. Under IRQ_MASK_BIOS_EN with quantum=2 in BIOS: no interrupt.
